muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle execute ALU. Handles mult/multu/div/divu iteratively and mfhi/mflo/mthi/mtlo. Drives a stall request so the pipeline holds while an operation is in flight.

Parameters:
WIDTH, 32, operand, HI and LO width (>= 4, power of 2)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
valid  in  1  op/reg1/reg2 present this cycle
op  in  6  R-type func: 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo, 011000 mult, 011001 multu, 011010 div, 011011 divu
reg1  in  WIDTH  rs value (multiplicand / dividend / mt source)
reg2  in  WIDTH  rt value (multiplier / divisor)
flush  in  1  abort in-flight operation
result  out  WIDTH  mfhi/mflo read data
busy  out  1  operation in flight
done  out  1  one-cycle pulse, HI/LO updated this edge
stall  out  1  pipeline hold request
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state IDLE, hi=lo=0, busy=0, done=0, result=0, counter=0, internal regs 0.
- States: IDLE, RUN, FIX.
- IDLE, valid & mult/multu/div/divu: latch magnitudes (signed ops: two's-complement absolute value; unsigned ops: raw), record sign flags, counter=WIDTH, -> RUN. busy=1 from next cycle.
- RUN: one radix-2 step per cycle; multiply = shift-add into 2*WIDTH accumulator; divide = restoring shift-subtract producing quotient/remainder. Counter decrements; at 1 -> FIX.
- FIX: apply signs (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign); write hi/lo (mult: hi=upper, lo=lower; div: hi=remainder, lo=quotient); done=1 for this cycle; -> IDLE; busy=0.
- Latency start-accept to done: WIDTH+1 cycles (33 at WIDTH=32).
- Divide by zero: no exception; hi=reg1 (dividend), lo=all ones; same latency.
- Signed min/-1 (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- mfhi/mflo: result = hi/lo combinationally when not busy; result=0 for other ops.
- mthi/mtlo while not busy: hi/lo = reg1 at next edge.
- stall = valid & (busy | state!=IDLE) & any listed op; valid op arriving while busy is not accepted and is re-presented by the pipeline.
- Back-to-back: op presented in the cycle done is high sees updated hi/lo and is accepted (FIX->IDLE transition completes same edge; stall low).
- flush: synchronous; in RUN/FIX -> IDLE next edge, busy=0, done=0, hi/lo unchanged. flush in IDLE blocks acceptance that cycle.
- rst mid-operation: immediate abort to reset values.
- op values outside the list: ignored, no stall.

Optional Feature:
MULDIV_FAST_MUL_EN: defined -> mult/multu complete in a single combinational multiply; IDLE -> FIX directly, latency 1 cycle (done one edge after accept), divide unchanged. Undefined -> iterative multiply, WIDTH+1 cycles.

Test Plan:
- Reset then mfhi/mflo -> result 0x00000000, busy=0, done=0.
- mult 0xFFFFFFFF x 0x00000002 -> after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 7/0 -> hi=0x00000007, lo=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no hang.
- mflo issued 5 cycles after mult start -> stall high until done cycle, then result = new lo.
- flush at cycle 10 of div after mthi 0x1234 -> busy drops next cycle, no done, hi remains 0x00001234; rst asserted mid-mult -> hi=lo=0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers and pipeline stall.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state | meaning
    // S_IDLE | waiting; mt/mf access to HI/LO, accepts new mult/div
    // S_RUN  | one radix-2 shift-add / shift-subtract step per cycle
    // S_FIX  | apply signs, write HI/LO, raise done next cycle

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t state_q, state_d;

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               div_zero_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               op_mul;
    logic               op_div;
    logic               op_signed;
    logic               op_listed;
    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_listed = op_mul || op_div || (op == OP_MFHI) || (op == OP_MTHI)
                       || (op == OP_MFLO) || (op == OP_MTLO);

    assign accept = valid && (op_mul || op_div) && !flush && (state_q == S_IDLE);

    assign a_neg = op_signed && reg1[WIDTH-1];
    assign b_neg = op_signed && reg2[WIDTH-1];
    assign mag_a = a_neg ? -reg1 : reg1;
    assign mag_b = b_neg ? -reg2 : reg2;

    // Multiply step: conditional add into the upper half, then shift right with carry.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: partial remainder in the upper half, quotient shifts into the lower.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, mag_b_q};
    assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    // Divide by zero leaves the magnitude dividend as remainder; quotient is forced to all ones.
    assign quo_fix  = div_zero_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_d = op_mul ? S_FIX : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            mag_b_q    <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        acc_q      <= {{WIDTH{1'b0}}, mag_a};
                        mag_b_q    <= mag_b;
                        cnt_q      <= CNT_W'(WIDTH);
                        is_div_q   <= op_div;
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= op_div && (reg2 == '0);
`ifdef MULDIV_FAST_MUL_EN
                        if (op_mul) begin
                            acc_q <= fast_prod;
                        end
`endif
                    end else if (valid && !flush) begin
                        if (op == OP_MTHI) begin
                            hi_q <= reg1;
                        end
                        if (op == OP_MTLO) begin
                            lo_q <= reg1;
                        end
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result = '0;
        if (valid && (state_q == S_IDLE)) begin
            if (op == OP_MFHI) begin
                result = hi_q;
            end else if (op == OP_MFLO) begin
                result = lo_q;
            end
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign stall = valid && op_listed && (state_q != S_IDLE);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
